// File: rtl/aes256_encrypt_ctrl.sv
// aes256_encrypt_ctrl: iterative AES-256 round sequencer with local final round; AES_CTRL_ABORT_EN adds the abort port.
module aes256_encrypt_ctrl #(
    parameter int NR = 14
) (
    input  logic         sys_clk,
    input  logic         sys_rst_n,
`ifdef AES_CTRL_ABORT_EN
    input  logic         abort,
`endif
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         key_ready,
    output logic [3:0]   key_idx,
    input  logic [127:0] key_data,
    output logic [127:0] dp_in,
    output logic [127:0] dp_key,
    input  logic [127:0] dp_out,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);
    typedef enum logic [2:0] {IDLE, ISSUE, CAPTURE, FINAL, DONE} state_t;
    state_t state_q, state_d;
    logic [127:0] st_q, st_d, out_data_q, out_data_d;
    logic [3:0] rnd_q, rnd_d;
    logic out_valid_q, out_valid_d;
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            p = b[i] ? p ^ x : p;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction
    // S-box as GF(2^8) inverse (x^254) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] s, v;
        s = a;
        v = 8'h01;
        for (int i = 1; i < 8; i++) begin
            s = gmul(s, s);
            v = gmul(v, s);
        end
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction
    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(r+4*c) -: 8] = sbox(s[127-8*(r+4*((c+r)%4)) -: 8]);
        return o;
    endfunction
    always_comb begin
        state_d     = state_q;
        st_d        = st_q;
        rnd_d       = rnd_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: if (in_valid && key_ready) begin
                st_d    = in_data ^ key_data;
                rnd_d   = 4'd1;
                state_d = ISSUE;
            end
            ISSUE: state_d = CAPTURE;
            CAPTURE: begin
                st_d    = dp_out;
                rnd_d   = (rnd_q == 4'(NR - 1)) ? rnd_q : rnd_q + 4'd1;
                state_d = (rnd_q == 4'(NR - 1)) ? FINAL : ISSUE;
            end
            FINAL: begin
                out_data_d  = sub_shift(st_q) ^ key_data;
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: if (out_ready) begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
`ifdef AES_CTRL_ABORT_EN
        if (abort && (state_q == ISSUE || state_q == CAPTURE || state_q == FINAL)) begin
            state_d     = IDLE;
            st_d        = '0;
            rnd_d       = '0;
            out_data_d  = out_data_q;
            out_valid_d = 1'b0;
        end
`endif
    end
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q     <= IDLE;
            st_q        <= '0;
            rnd_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            st_q        <= st_d;
            rnd_q       <= rnd_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end
    assign in_ready  = (state_q == IDLE) && key_ready;
    assign key_idx   = (state_q == IDLE) ? 4'd0 : (state_q == FINAL) ? 4'(NR) : rnd_q;
    assign dp_in     = st_q;
    assign dp_key    = key_data;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = state_q != IDLE;
endmodule

// File: tb/tb_aes256_encrypt_ctrl.sv
// tb_aes256_encrypt_ctrl: randomized bench with a block-level AES-256 reference and per-cycle output comparison.
module tb_aes256_encrypt_ctrl;
    logic sys_clk = 0, sys_rst_n = 0, in_valid = 0, key_ready = 0, out_ready = 0, abort = 0;
    logic [127:0] in_data = '0, key_data, dp_in, dp_key, dp_out = '0, out_data;
    logic [3:0] key_idx;
    logic in_ready, out_valid, busy;
    logic [7:0] sb [256];
    logic [127:0] rk [16];
    int n_chk = 0, n_fail = 0, cyc = 0, n_acc = 0, n_out = 0, last_acc = 0, prev_acc = 0, m_cnt = 0;
    bit chk_en = 0, m_active = 0, m_valid = 0;
    logic [127:0] m_ct = '0, m_exp = '0;
    wire mb = m_active || m_valid;

    aes256_encrypt_ctrl #(.NR(14)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
`ifdef AES_CTRL_ABORT_EN
        .abort(abort),
`endif
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .key_ready(key_ready), .key_idx(key_idx), .key_data(key_data),
        .dp_in(dp_in), .dp_key(dp_key), .dp_out(dp_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
    );

    always #5 sys_clk = ~sys_clk;
    assign key_data = rk[key_idx];

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction
    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
    endfunction
    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k, input bit mix);
        logic [7:0] a [16];
        logic [7:0] t [16];
        logic [127:0] o;
        for (int n = 0; n < 16; n++) a[n] = sb[s[127-8*n -: 8]];
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) t[r+4*c] = a[r+4*((c+r)%4)];
        for (int c = 0; c < 4; c++)
            o[127-32*c -: 32] = mix ?
                {xt(t[4*c]) ^ xt(t[4*c+1]) ^ t[4*c+1] ^ t[4*c+2] ^ t[4*c+3],
                 t[4*c] ^ xt(t[4*c+1]) ^ xt(t[4*c+2]) ^ t[4*c+2] ^ t[4*c+3],
                 t[4*c] ^ t[4*c+1] ^ xt(t[4*c+2]) ^ xt(t[4*c+3]) ^ t[4*c+3],
                 xt(t[4*c]) ^ t[4*c] ^ t[4*c+1] ^ t[4*c+2] ^ xt(t[4*c+3])} :
                {t[4*c], t[4*c+1], t[4*c+2], t[4*c+3]};
        return o ^ k;
    endfunction
    function automatic logic [127:0] aes_enc(input logic [127:0] pt);
        logic [127:0] s;
        s = pt ^ rk[0];
        for (int r = 1; r < 14; r++) s = aes_round(s, rk[r], 1'b1);
        return aes_round(s, rk[14], 1'b0);
    endfunction
    task automatic expand(input logic [255:0] k);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0] rc;
        rc = 8'h01;
        for (int i = 0; i < 8; i++) w[i] = k[255-32*i -: 32];
        for (int i = 8; i < 60; i++) begin
            t = w[i-1];
            if (i % 8 == 0) begin
                t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xt(rc);
            end else if (i % 8 == 4) t = subw(t);
            w[i] = w[i-8] ^ t;
        end
        for (int r = 0; r < 15; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        rk[15] = '0;
    endtask
    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction
    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask
    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask
    task automatic wait_acc(input int target);
        int k = 0;
        while (n_acc < target && k < 80) begin tick(); k++; end
        chk("accept_timeout", 128'(n_acc >= target), 128'(1));
    endtask
    task automatic wait_out_valid();
        int k = 0;
        while (!out_valid && k < 80) begin tick(); k++; end
        chk("out_valid_timeout", 128'(out_valid), 128'(1));
    endtask
    task automatic run_block(input bit rand_ready);
        int a, o, k;
        k = 0;
        out_ready = 1;
        while (mb && k < 80) begin tick(); k++; end
        out_ready = 0;
        key_ready = 1;
        a = n_acc;
        o = n_out;
        in_data = rand128();
        in_valid = 1;
        wait_acc(a + 1);
        in_valid = 0;
        k = 0;
        while (n_out == o && k < 200) begin
            out_ready = rand_ready ? 1'($urandom % 2) : 1'b1;
            tick();
            k++;
        end
        chk("block_done_timeout", 128'(n_out - o), 128'(1));
        out_ready = 0;
    endtask

    // Block-level reference: accept, 27 edges of processing, hold until consumed.
    always @(posedge sys_clk) begin
        cyc <= cyc + 1;
        if (!sys_rst_n) begin
            m_active <= 0; m_valid <= 0; m_cnt <= 0; m_ct <= '0;
        end else if (m_active) begin
            if (abort) m_active <= 0;
            else if (m_cnt == 26) begin m_active <= 0; m_valid <= 1; m_ct <= m_exp; end
            else m_cnt <= m_cnt + 1;
        end else if (m_valid) begin
            if (out_ready) begin m_valid <= 0; n_out <= n_out + 1; end
        end else if (in_valid && key_ready) begin
            m_active <= 1; m_cnt <= 0; m_exp <= aes_enc(in_data);
            prev_acc <= last_acc; last_acc <= cyc; n_acc <= n_acc + 1;
        end
    end

    always @(posedge sys_clk) dp_out <= aes_round(dp_in, dp_key, 1'b1);

    always @(negedge sys_clk) begin
        if (chk_en) begin
            chk("in_ready", 128'(in_ready), 128'(!mb && key_ready));
            chk("busy", 128'(busy), 128'(mb));
            chk("out_valid", 128'(out_valid), 128'(m_valid));
            chk("out_data", out_data, m_ct);
            chk("dp_key", dp_key, key_data);
            if (!mb) chk("key_idx_idle", 128'(key_idx), 128'(0));
            else if (m_active && m_cnt == 26) chk("key_idx_final", 128'(key_idx), 128'(14));
            else if (m_active && m_cnt % 2 == 0) chk("key_idx_issue", 128'(key_idx), 128'(m_cnt / 2 + 1));
        end
    end

    initial begin
        logic [7:0] p, q;
        logic [127:0] ct;
        int a, o, k;
        p = 8'h01;
        q = 8'h01;
        repeat (255) begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b0};
            q = q ^ {q[3:0], 4'b0};
            if (q[7]) q = q ^ 8'h09;
            sb[p] = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]} ^ 8'h63;
        end
        sb[0] = 8'h63;
        chk("sbox_00", 128'(sb[8'h00]), 128'h63);
        chk("sbox_01", 128'(sb[8'h01]), 128'h7c);
        chk("sbox_10", 128'(sb[8'h10]), 128'hca);
        chk("sbox_53", 128'(sb[8'h53]), 128'hed);
        chk("sbox_ff", 128'(sb[8'hff]), 128'h16);
        expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
        ct = aes_enc(128'h00112233445566778899aabbccddeeff);
        chk("model_fips", ct, 128'h8ea2b7ca516745bfeafc49904b496089);
        chk_en = 1;
        repeat (2) tick();
        sys_rst_n = 1;
        chk("rst_out_data", out_data, '0);
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_key_idx", 128'(key_idx), 128'(0));
        chk("rst_out_valid", 128'(out_valid), 128'(0));

        // FIPS-197 vector, first held off by key_ready
        in_data = 128'h00112233445566778899aabbccddeeff;
        in_valid = 1;
        repeat (10) tick();
        chk("no_key_busy", 128'(busy), 128'(0));
        chk("no_key_acc", 128'(n_acc), 128'(0));
        key_ready = 1;
        tick();
        chk("key_ready_accept", 128'(n_acc), 128'(1));
        in_valid = 0;
        out_ready = 1;
        k = 0;
        while (!out_valid && k < 40) begin tick(); k++; end
        chk("fips_latency", 128'(k), 128'(27));
        chk("fips_ct", out_data, 128'h8ea2b7ca516745bfeafc49904b496089);
        tick();
        chk("fips_valid_1cyc", 128'(out_valid), 128'(0));

        // backpressure
        out_ready = 0;
        expand({rand128(), rand128()});
        in_data = rand128();
        ct = aes_enc(in_data);
        a = n_acc;
        in_valid = 1;
        wait_acc(a + 1);
        in_valid = 0;
        wait_out_valid();
        repeat (20) tick();
        chk("bp_hold_data", out_data, ct);
        chk("bp_in_ready", 128'(in_ready), 128'(0));
        out_ready = 1;
        tick();
        chk("bp_release_valid", 128'(out_valid), 128'(0));
        chk("bp_release_busy", 128'(busy), 128'(0));

        // back-to-back with in_valid held
        a = n_acc;
        o = n_out;
        in_data = rand128();
        in_valid = 1;
        wait_acc(a + 1);
        in_data = rand128();
        wait_acc(a + 2);
        in_valid = 0;
        chk("b2b_period", 128'(last_acc - prev_acc), 128'(29));
        k = 0;
        while (n_out < o + 2 && k < 60) begin tick(); k++; end
        chk("b2b_outs", 128'(n_out - o), 128'(2));

        // reset during round 7
        a = n_acc;
        o = n_out;
        in_data = rand128();
        in_valid = 1;
        wait_acc(a + 1);
        in_valid = 0;
        repeat (12) tick();
        sys_rst_n = 0;
        tick();
        sys_rst_n = 1;
        chk("midrst_busy", 128'(busy), 128'(0));
        chk("midrst_out_data", out_data, '0);
        chk("midrst_key_idx", 128'(key_idx), 128'(0));
        repeat (35) tick();
        chk("midrst_no_out", 128'(n_out - o), 128'(0));
        run_block(1'b0);

`ifdef AES_CTRL_ABORT_EN
        a = n_acc;
        o = n_out;
        in_data = rand128();
        in_valid = 1;
        wait_acc(a + 1);
        in_valid = 0;
        repeat (8) tick();
        abort = 1;
        tick();
        abort = 0;
        chk("abort_busy", 128'(busy), 128'(0));
        repeat (35) tick();
        chk("abort_no_out", 128'(n_out - o), 128'(0));
        out_ready = 0;
        in_data = rand128();
        ct = aes_enc(in_data);
        in_valid = 1;
        wait_acc(a + 2);
        in_valid = 0;
        wait_out_valid();
        abort = 1;
        tick();
        abort = 0;
        chk("abort_done_valid", 128'(out_valid), 128'(1));
        chk("abort_done_data", out_data, ct);
        out_ready = 1;
        tick();
        chk("abort_done_out", 128'(n_out - o), 128'(1));
        out_ready = 0;
`endif

        for (int b = 0; b < 6; b++) begin
            expand({rand128(), rand128()});
            run_block(1'b1);
        end
        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/aes256_encrypt_ctrl.md
# aes256_encrypt_ctrl

- Iterative AES-256 encryption sequencer.
- Accepts one 128-bit plaintext block per handshake and performs the initial AddRoundKey.
- Drives the shared single-round datapath (SubBytes→ShiftRows→MixColumns→AddRoundKey, 1-cycle registered) for rounds 1–13.
- Computes the final round (no MixColumns) locally with its own SubBytes and ShiftRows instances, then presents the ciphertext on a valid/ready output.
- Sits between the key-schedule store (indexed round-key reads) and the round datapath.

## Interface
Parameters:
- NR, 14, number of AES rounds; fixed for AES-256, no other value supported.

Ports:
- sys_clk  in  1  single clock; all state changes on rising edge.
- sys_rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  plaintext block offered.
- in_ready  out  1  block accepted when in_valid && in_ready at a rising edge.
- in_data  in  128  plaintext.
- key_ready  in  1  key schedule for the current key is complete.
- key_idx  out  4  round-key index requested, 0..14.
- key_data  in  128  round key for key_idx, valid combinationally in the same cycle.
- dp_in  out  128  state to the round datapath.
- dp_key  out  128  round key to the round datapath; equals key_data.
- dp_out  in  128  round datapath registered output, valid one edge after dp_in/dp_key.
- out_valid  out  1  ciphertext valid.
- out_ready  in  1  consumer accepts ciphertext.
- out_data  out  128  ciphertext.
- busy  out  1  high in every state except IDLE.
- abort  in  1  present only with AES_CTRL_ABORT_EN.

## Operation
States: IDLE, ISSUE, CAPTURE, FINAL, DONE. Registers: st[127:0], rnd[3:0], out_data, out_valid.

- **IDLE**
  - key_idx=0; in_ready = key_ready.
  - On accept: st <= in_data ^ key_data, rnd <= 1, go to ISSUE.
- **ISSUE**
  - key_idx = rnd; dp_in = st; dp_key = key_data.
  - Go to CAPTURE unconditionally.
- **CAPTURE**
  - st <= dp_out.
  - If rnd==13: go to FINAL. Otherwise rnd <= rnd+1 and go to ISSUE.
- **FINAL**
  - key_idx = 14.
  - out_data <= ShiftRows(SubBytes(st)) ^ key_data; out_valid <= 1; go to DONE.
- **DONE**
  - Hold out_data and out_valid stable.
  - On out_valid && out_ready: out_valid <= 0, go to IDLE.

General rules:
- in_ready is 0 in every state except IDLE. No new block is accepted until the ciphertext has been consumed.
- dp_in = st and dp_key = key_data in all states. The datapath output is only sampled in CAPTURE.
- rnd never exceeds 13 and never wraps.
- key_ready deasserting mid-block has no effect on the block in flight. The key store must not change contents while busy.
- All data paths are pure XOR/permutation with no width growth.

## Timing
- Reset: state=IDLE, st=0, rnd=0, out_data=0, out_valid=0, busy=0, key_idx=0. in_ready follows key_ready once out of reset.
- Reset asserted in any state: next edge forces the reset values and discards the block in flight. No out_valid is produced for it.
- Let E0 be the accept edge:
  - Round r (1..13) is issued in the cycle after edge E(2r−2) and captured at edge E(2r).
  - FINAL is the cycle after E26.
  - out_valid rises after edge E27, i.e. 27 edges after acceptance.
- out_ready may be high before out_valid. The first cycle with out_valid high then completes the transfer, and out_valid drops after the next edge.
- Minimum block period is 29 cycles: 27 cycles of processing, ≥1 in DONE, 1 in IDLE.

## Configuration
- AES_CTRL_ABORT_EN defined:
  - abort port exists.
  - abort high at an edge in ISSUE, CAPTURE or FINAL returns to IDLE with out_valid=0, st and rnd cleared.
  - abort in IDLE or DONE is ignored; a completed ciphertext is never dropped.
  - sys_rst_n takes priority over abort.
- Not defined: no abort port; the FSM is exactly as above.

## Test plan
- FIPS-197 C.3 vector:
  - Stimulus: key 000102…1f (bench key-schedule model on key_idx/key_data), plaintext 00112233445566778899aabbccddeeff, out_ready=1.
  - Required response: out_data=8ea2b7ca516745bfeafc49904b496089, out_valid rising 27 edges after accept and high for exactly 1 cycle.
- key_ready=0 with in_valid=1 for 10 cycles → in_ready=0 and busy=0 throughout. Raising key_ready gives accept on the next edge.
- Backpressure: out_ready=0 for 20 cycles after out_valid → out_data stable, in_ready=0. Raising out_ready gives out_valid=0 and IDLE on the next edge.
- Back-to-back: two blocks with in_valid held high and out_ready=1 → both ciphertexts correct; second accept occurs 29 cycles after the first.
- Reset mid-operation: sys_rst_n=0 for 1 cycle at round 7 → all outputs at reset values. No out_valid follows; the next block encrypts correctly.
- AES_CTRL_ABORT_EN build: abort pulse at round 5 → IDLE with no out_valid. abort pulse in DONE → ciphertext still delivered unchanged.
